// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, synchronous flush and an
// optional two-entry skid buffer that keeps out_ready off the upstream ready path.
module pipe_stage_skid #(
    parameter int CTRL_W = 10,
    parameter int DATA_W = 37,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic              m_valid_q, m_valid_d;
    logic              s_valid_q, s_valid_d;
    logic              in_ready_q, in_ready_d;
    logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
    logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic [DATA_W-1:0] s_data_q, s_data_d;
    logic              in_xfer;
    logic              out_xfer;

    // Skid mode presents a registered ready; single-register mode forwards out_ready.
    assign in_ready = (SKID != 0) ? in_ready_q : (out_ready | ~m_valid_q);
    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = m_valid_q & out_ready;

    always_comb begin
        m_valid_d = m_valid_q;
        s_valid_d = s_valid_q;
        m_ctrl_d  = m_ctrl_q;
        s_ctrl_d  = s_ctrl_q;
        m_data_d  = m_data_q;
        s_data_d  = s_data_q;

        if (flush) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
            m_ctrl_d  = '0;
            s_ctrl_d  = '0;
        end else if (SKID == 0) begin
            if (in_xfer) begin
                m_valid_d = 1'b1;
                m_ctrl_d  = in_ctrl;
                m_data_d  = in_data;
            end else if (out_xfer) begin
                m_valid_d = 1'b0;
            end
        end else if (s_valid_q) begin
            // Full: nothing can enter; a drain promotes the skid entry.
            if (out_xfer) begin
                m_ctrl_d  = s_ctrl_q;
                m_data_d  = s_data_q;
                s_valid_d = 1'b0;
            end
        end else if (in_xfer) begin
            if (!m_valid_q || out_ready) begin
                m_valid_d = 1'b1;
                m_ctrl_d  = in_ctrl;
                m_data_d  = in_data;
            end else begin
                s_valid_d = 1'b1;
                s_ctrl_d  = in_ctrl;
                s_data_d  = in_data;
            end
        end else if (out_xfer) begin
            m_valid_d = 1'b0;
        end

        in_ready_d = ~s_valid_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid_q  <= 1'b0;
            s_valid_q  <= 1'b0;
            in_ready_q <= 1'b1;
            m_ctrl_q   <= '0;
            s_ctrl_q   <= '0;
        end else begin
            m_valid_q  <= m_valid_d;
            s_valid_q  <= s_valid_d;
            in_ready_q <= in_ready_d;
            m_ctrl_q   <= m_ctrl_d;
            s_ctrl_q   <= s_ctrl_d;
        end
    end

    // Payload is qualified by the valid bits, so it carries no reset.
    always_ff @(posedge clk) begin
        m_data_q <= m_data_d;
        s_data_q <= s_data_d;
    end

    assign out_valid = m_valid_q;
    assign out_ctrl  = m_valid_q ? m_ctrl_q : '0;
    assign out_data  = m_data_q;
    assign occupancy = {1'b0, m_valid_q} + {1'b0, s_valid_q};

    // The skid entry is only ever filled behind a held main entry.
    assert property (@(posedge clk) disable iff (reset) !(s_valid_q && !m_valid_q));

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: a SKID=1 and a SKID=0 instance, each checked every
// cycle against a queue model, plus directed cases with literal expectations.
module tb_pipe_stage_skid;

    localparam int CW = 10;
    localparam int DW = 37;

    typedef struct {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } item_t;

    logic clk = 1'b0;
    logic reset;

    logic          v1, r1, f1, ov1, or1;
    logic [CW-1:0] c1, oc1;
    logic [DW-1:0] d1, od1;
    logic [1:0]    occ1;

    logic          v0, r0, f0, ov0, or0;
    logic [CW-1:0] c0, oc0;
    logic [DW-1:0] d0, od0;
    logic [1:0]    occ0;

    item_t q1[$];
    item_t q0[$];
    bit    hold1, hold0;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .SKID(1)) dut1 (
        .clk(clk), .reset(reset),
        .in_valid(v1), .in_ready(r1), .in_ctrl(c1), .in_data(d1),
        .flush(f1),
        .out_valid(ov1), .out_ready(or1), .out_ctrl(oc1), .out_data(od1),
        .occupancy(occ1)
    );

    pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .SKID(0)) dut0 (
        .clk(clk), .reset(reset),
        .in_valid(v0), .in_ready(r0), .in_ctrl(c0), .in_data(d0),
        .flush(f0),
        .out_valid(ov0), .out_ready(or0), .out_ctrl(oc0), .out_data(od0),
        .occupancy(occ0)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        chk("ov1", 64'(ov1), 64'(q1.size() != 0));
        chk("oc1", 64'(oc1), (q1.size() != 0) ? 64'(q1[0].c) : 64'd0);
        if (q1.size() != 0) chk("od1", 64'(od1), 64'(q1[0].d));
        chk("occ1", 64'(occ1), 64'(q1.size()));
        chk("ir1", 64'(r1), 64'(q1.size() < 2));
        chk("ov0", 64'(ov0), 64'(q0.size() != 0));
        chk("oc0", 64'(oc0), (q0.size() != 0) ? 64'(q0[0].c) : 64'd0);
        if (q0.size() != 0) chk("od0", 64'(od0), 64'(q0[0].d));
        chk("occ0", 64'(occ0), 64'(q0.size()));
        chk("ir0", 64'(r0), 64'(or0 || q0.size() == 0));
    endtask

    // FIFO view of the stage: capacity 2 (skid) or 1 (plain register).
    task automatic model_update();
        bit rdy, xin, xout;
        item_t it;
        rdy  = q1.size() < 2;
        xin  = v1 && rdy;
        xout = (q1.size() != 0) && or1;
        if (f1) q1.delete();
        else begin
            if (xout) void'(q1.pop_front());
            if (xin) begin it.c = c1; it.d = d1; q1.push_back(it); end
        end
        hold1 = v1 && !rdy && !f1;

        rdy  = or0 || (q0.size() == 0);
        xin  = v0 && rdy;
        xout = (q0.size() != 0) && or0;
        if (f0) q0.delete();
        else begin
            if (xout) void'(q0.pop_front());
            if (xin) begin it.c = c0; it.d = d0; q0.push_back(it); end
        end
        hold0 = v0 && !rdy && !f0;
    endtask

    // Entered at a falling edge with inputs set; returns at the next falling edge.
    task automatic tick();
        #1 compare_all();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic rand_item(output logic [CW-1:0] c, output logic [DW-1:0] d);
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        d = r[DW-1:0];
        c = CW'($urandom());
    endtask

    initial begin
        reset = 1'b1;
        v1 = 0; c1 = '0; d1 = '0; f1 = 0; or1 = 1;
        v0 = 0; c0 = '0; d0 = '0; f0 = 0; or0 = 1;
        hold1 = 0; hold0 = 0;
        repeat (3) @(negedge clk);
        chk("rst_ov1", 64'(ov1), 64'd0);
        chk("rst_occ1", 64'(occ1), 64'd0);
        chk("rst_ir1", 64'(r1), 64'd1);
        chk("rst_oc1", 64'(oc1), 64'd0);
        reset = 1'b0;

        // Streaming 1,2,3 through the skid instance.
        for (int i = 1; i <= 3; i++) begin
            v1 = 1; d1 = DW'(i); c1 = CW'(i);
            tick();
            chk("stream_data", 64'(od1), 64'(i));
            chk("stream_occ", 64'(occ1), 64'd1);
            chk("stream_ir", 64'(r1), 64'd1);
        end
        v1 = 0;
        tick();
        chk("stream_drain", 64'(occ1), 64'd0);

        // Stall into the skid entry, then release.
        or1 = 0; v1 = 1; d1 = DW'(10); c1 = CW'(1);
        tick();
        chk("stall_occ_a", 64'(occ1), 64'd1);
        chk("stall_ir_a", 64'(r1), 64'd1);
        d1 = DW'(11);
        tick();
        chk("stall_occ_b", 64'(occ1), 64'd2);
        chk("stall_ir_b", 64'(r1), 64'd0);
        d1 = DW'(12);
        tick();
        chk("stall_hold_occ", 64'(occ1), 64'd2);
        chk("stall_head", 64'(od1), 64'd10);
        or1 = 1;
        tick();
        chk("release_b", 64'(od1), 64'd11);
        chk("release_occ", 64'(occ1), 64'd1);
        chk("release_ir", 64'(r1), 64'd1);
        tick();
        chk("release_c", 64'(od1), 64'd12);
        v1 = 0;
        tick();
        chk("release_empty", 64'(ov1), 64'd0);

        // Flush with two held items and an offered item.
        or1 = 0; v1 = 1; d1 = DW'(20); c1 = CW'(5);
        tick();
        d1 = DW'(21);
        tick();
        f1 = 1; d1 = DW'(99);
        tick();
        chk("flush_ov", 64'(ov1), 64'd0);
        chk("flush_oc", 64'(oc1), 64'd0);
        chk("flush_occ", 64'(occ1), 64'd0);
        chk("flush_ir", 64'(r1), 64'd1);
        f1 = 0; v1 = 0; or1 = 1;
        tick();
        chk("flush_no_x", 64'(ov1), 64'd0);

        // Bubble masking of control bits.
        v1 = 1; c1 = 10'h3FF; d1 = DW'(7);
        tick();
        chk("bubble_ctrl_on", 64'(oc1), 64'h3FF);
        v1 = 0;
        tick();
        chk("bubble_ctrl_off", 64'(oc1), 64'd0);
        chk("bubble_valid", 64'(ov1), 64'd0);

        // Combinational ready on the plain-register instance.
        or0 = 0; v0 = 1; d0 = DW'(5); c0 = CW'(7);
        tick();
        chk("s0_data5", 64'(od0), 64'd5);
        d0 = DW'(6);
        #1 chk("s0_ir_low", 64'(r0), 64'd0);
        or0 = 1;
        #1 chk("s0_ir_high", 64'(r0), 64'd1);
        or0 = 0;
        #1 chk("s0_ir_low2", 64'(r0), 64'd0);
        or0 = 1;
        tick();
        chk("s0_data6", 64'(od0), 64'd6);
        chk("s0_occ", 64'(occ0), 64'd1);
        v0 = 0;
        tick();
        chk("s0_empty_oc", 64'(oc0), 64'd0);

        // Randomized traffic on both instances.
        for (int n = 0; n < 3000; n++) begin
            if (!hold1) begin
                v1 = ($urandom_range(0, 3) != 0);
                rand_item(c1, d1);
            end
            if (!hold0) begin
                v0 = ($urandom_range(0, 3) != 0);
                rand_item(c0, d0);
            end
            or1 = ($urandom_range(0, 1) != 0);
            or0 = ($urandom_range(0, 1) != 0);
            f1  = ($urandom_range(0, 31) == 0);
            f0  = ($urandom_range(0, 31) == 0);
            tick();
        end

        // Asynchronous reset while the skid instance holds two items.
        f1 = 0; f0 = 0; or1 = 0; or0 = 0;
        v1 = 1; d1 = DW'(30); c1 = CW'(3);
        v0 = 1; d0 = DW'(40); c0 = CW'(4);
        if (hold1 || hold0) begin
            v1 = 0; v0 = 0; or1 = 1; or0 = 1;
            repeat (3) tick();
            or1 = 0; or0 = 0; v1 = 1; v0 = 1;
        end
        tick();
        v0 = 0; d1 = DW'(31);
        tick();
        chk("pre_rst_occ1", 64'(occ1), 64'd2);
        chk("pre_rst_occ0", 64'(occ0), 64'd1);
        v1 = 0;
        #2 reset = 1'b1;
        #1;
        chk("arst_ov1", 64'(ov1), 64'd0);
        chk("arst_oc1", 64'(oc1), 64'd0);
        chk("arst_occ1", 64'(occ1), 64'd0);
        chk("arst_ir1", 64'(r1), 64'd1);
        chk("arst_ov0", 64'(ov0), 64'd0);
        chk("arst_occ0", 64'(occ0), 64'd0);
        q1.delete(); q0.delete(); hold1 = 0; hold0 = 0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if (!hold1) begin v1 = ($urandom_range(0, 1) != 0); rand_item(c1, d1); end
            if (!hold0) begin v0 = ($urandom_range(0, 1) != 0); rand_item(c0, d0); end
            or1 = ($urandom_range(0, 1) != 0);
            or0 = ($urandom_range(0, 1) != 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
